// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the memory model and mem_port_arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_err;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;
  logic              dma_err;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              grant;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack, dma_err,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output grant, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack, dma_err,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  grant, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU, DMA) arbiter for the unified memory; one access at a time, timeout on MAX_WAIT.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed CPU priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Counter holds the number of completed ACCESS cycles; timeout fires on the MAX_WAIT-th.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t            state;
  logic [7:0]        wait_cnt;

  logic              pick_dma;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              access_done;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_grant;
`endif

  always_comb begin
    pick_dma = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (bus.cpu_req && bus.dma_req) begin
      pick_dma = ~last_grant;
    end else begin
      pick_dma = bus.dma_req;
    end
`else
    pick_dma = ~bus.cpu_req;
`endif
    we_sel    = pick_dma ? bus.dma_we    : bus.cpu_we;
    addr_sel  = pick_dma ? bus.dma_addr  : bus.cpu_addr;
    wdata_sel = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
  end

  // mem_ready on the timeout cycle still counts as a successful access.
  always_comb begin
    access_done = bus.mem_ready || (wait_cnt == LAST_WAIT);
    resp_err    = ~bus.mem_ready;
    resp_data   = (bus.mem_ready && bus.mem_read) ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_ack   <= 1'b0;
      bus.dma_err   <= 1'b0;
      bus.dma_rdata <= '0;
      bus.grant     <= 1'b0;
      bus.busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            state         <= ACCESS;
            wait_cnt      <= '0;
            bus.grant     <= pick_dma;
            bus.mem_addr  <= addr_sel;
            bus.mem_wdata <= wdata_sel;
            bus.mem_read  <= ~we_sel;
            bus.mem_write <= we_sel;
            bus.busy      <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= pick_dma;
`endif
          end
        end

        ACCESS: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (access_done) begin
            state         <= RESP;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            if (bus.grant) begin
              bus.dma_ack   <= 1'b1;
              bus.dma_err   <= resp_err;
              bus.dma_rdata <= resp_data;
            end else begin
              bus.cpu_ack   <= 1'b1;
              bus.cpu_err   <= resp_err;
              bus.cpu_rdata <= resp_data;
            end
          end
        end

        RESP: begin
          state         <= IDLE;
          wait_cnt      <= '0;
          bus.busy      <= 1'b0;
          bus.cpu_ack   <= 1'b0;
          bus.cpu_err   <= 1'b0;
          bus.cpu_rdata <= '0;
          bus.dma_ack   <= 1'b0;
          bus.dma_err   <= 1'b0;
          bus.dma_rdata <= '0;
        end

        default: begin
          state         <= IDLE;
          wait_cnt      <= '0;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; define ARB_ROUND_ROBIN_EN here too to check the round-robin build.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic init_inputs();
    bus.cpu_req   = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req   = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.mem_rdata = '0;   bus.mem_ready = 1'b0;
  endtask

  // Issues one access and plays memory: mem_ready is raised in ACCESS cycle ready_at (0 = never).
  task automatic run_access(input bit is_dma, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int unsigned ready_at,
                            input logic [31:0] rd, output int unsigned lat,
                            output int unsigned strobes, output logic [31:0] rdata,
                            output logic err, output bit stray_ack);
    lat = 0; strobes = 0; rdata = 'x; err = 1'bx; stray_ack = 1'b0;
    @(negedge clk);
    if (is_dma) begin
      bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
    bus.mem_rdata = rd;
    for (int unsigned k = 1; k <= 40; k++) begin
      @(negedge clk);
      stray_ack = stray_ack | (is_dma ? bus.cpu_ack : bus.dma_ack);
      if (is_dma ? bus.dma_ack : bus.cpu_ack) begin
        lat   = k;
        rdata = is_dma ? bus.dma_rdata : bus.cpu_rdata;
        err   = is_dma ? bus.dma_err : bus.cpu_err;
        break;
      end
      if (bus.mem_read || bus.mem_write) strobes++;
      bus.mem_ready = (k == ready_at);
    end
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    init_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.cpu_ack, bus.cpu_err, bus.dma_ack, bus.dma_err,
         bus.grant, bus.busy} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=00000000", {bus.mem_read, bus.mem_write, bus.cpu_ack,
               bus.cpu_err, bus.dma_ack, bus.dma_err, bus.grant, bus.busy});
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem got addr=%h wdata=%h exp 0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.cpu_rdata !== 32'h0 || bus.dma_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got cpu=%h dma=%h exp 0", bus.cpu_rdata, bus.dma_rdata);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_read !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req got busy=%b mem_read=%b exp 0", bus.busy, bus.mem_read);
    end
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h40 ||
        bus.grant !== 1'b0 || bus.busy !== 1'b1 || bus.cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_access got rd=%b wr=%b addr=%h grant=%b busy=%b ack=%b exp 1 0 40 0 1 0",
               bus.mem_read, bus.mem_write, bus.mem_addr, bus.grant, bus.busy, bus.cpu_ack);
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.mem_ready = 1'b0; bus.cpu_req = 1'b0;
    checks++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF || bus.cpu_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_resp got ack=%b rdata=%h err=%b exp 1 deadbeef 0",
               bus.cpu_ack, bus.cpu_rdata, bus.cpu_err);
    end
    checks++;
    if (bus.dma_ack !== 1'b0 || bus.dma_rdata !== 32'h0 || bus.mem_read !== 1'b0) begin
      errors++;
      $display("FAIL rd_loser got dma_ack=%b dma_rdata=%h mem_read=%b exp 0 0 0",
               bus.dma_ack, bus.dma_rdata, bus.mem_read);
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_ack !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_ack_pulse got ack=%b busy=%b exp 0 0", bus.cpu_ack, bus.busy);
    end
  endtask

  task automatic test_dma_write();
    int unsigned good;
    good = 0;
    @(negedge clk);
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h100; bus.dma_wdata = 32'h12345678;
    bus.mem_rdata = 32'hCAFEF00D;
    for (int unsigned k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (bus.mem_write === 1'b1 && bus.mem_read === 1'b0 && bus.mem_addr === 32'h100 &&
          bus.mem_wdata === 32'h12345678 && bus.grant === 1'b1 && bus.dma_ack === 1'b0)
        good++;
      if (k == 1) begin
        bus.dma_addr = 32'hFFFF0000; bus.dma_wdata = 32'h0;
      end
      bus.mem_ready = (k == 3);
    end
    checks++;
    if (good != 3) begin
      errors++;
      $display("FAIL wr_strobe_cycles got=%0d exp=3", good);
    end
    @(negedge clk);
    bus.mem_ready = 1'b0; bus.dma_req = 1'b0;
    checks++;
    if (bus.dma_ack !== 1'b1 || bus.dma_rdata !== 32'h0 || bus.dma_err !== 1'b0 ||
        bus.cpu_ack !== 1'b0 || bus.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL wr_resp got ack=%b rdata=%h err=%b cpu_ack=%b mem_write=%b exp 1 0 0 0 0",
               bus.dma_ack, bus.dma_rdata, bus.dma_err, bus.cpu_ack, bus.mem_write);
    end
    @(negedge clk);
    checks++;
    if (bus.dma_ack !== 1'b0 || bus.busy !== 1'b0 || bus.grant !== 1'b1) begin
      errors++;
      $display("FAIL wr_after got ack=%b busy=%b grant=%b exp 0 0 1", bus.dma_ack, bus.busy, bus.grant);
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] got;
    logic [3:0] exp_seq;
    int unsigned n;
    bit both;
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = 4'b1010;  // bit i = owner of ack i: CPU, DMA, CPU, DMA
`else
    exp_seq = 4'b0000;
`endif
    got = '0; n = 0; both = 1'b0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h20;
    bus.mem_rdata = 32'h1;
    for (int unsigned c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus.cpu_ack && bus.dma_ack) both = 1'b1;
      if (bus.cpu_ack || bus.dma_ack) begin
        got[n] = bus.dma_ack;
        n++;
        if (n == 4) begin
          bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        end
      end
      bus.mem_ready = bus.mem_read;
    end
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL arb_ack_count got=%0d exp=4", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_seq[i]) begin
        errors++;
        $display("FAIL arb_order[%0d] got owner=%b exp=%b", i, got[i], exp_seq[i]);
      end
    end
    checks++;
    if (both) begin
      errors++;
      $display("FAIL arb_double_ack got both acks high exp never");
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL arb_drain got busy=%b exp 0", bus.busy);
    end
  endtask

  task automatic test_loser_pending();
    int unsigned cpu_at, dma_at;
    logic dma_grant;
    cpu_at = 0; dma_at = 0; dma_grant = 1'b0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h30;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h34;
    for (int unsigned c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.cpu_ack && cpu_at == 0) begin
        cpu_at = c; bus.cpu_req = 1'b0;
      end
      if (bus.dma_ack) begin
        dma_at = c; dma_grant = bus.grant; bus.dma_req = 1'b0;
        break;
      end
      bus.mem_ready = bus.mem_read;
    end
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.mem_ready = 1'b0;
    checks++;
    if (cpu_at != 2 || dma_at != 5 || dma_grant !== 1'b1) begin
      errors++;
      $display("FAIL loser_pending got cpu_ack@%0d dma_ack@%0d grant=%b exp 2 5 1",
               cpu_at, dma_at, dma_grant);
    end
  endtask

  task automatic test_timeout();
    int unsigned lat, strobes;
    logic [31:0] rdata;
    logic err;
    bit stray;
    run_access(1'b0, 1'b0, 32'h80, 32'h0, 0, 32'hFFFFFFFF, lat, strobes, rdata, err, stray);
    checks++;
    if (lat != 16 || strobes != 15) begin
      errors++;
      $display("FAIL timeout_latency got ack@%0d strobes=%0d exp 16 15", lat, strobes);
    end
    checks++;
    if (err !== 1'b1 || rdata !== 32'h0 || stray) begin
      errors++;
      $display("FAIL timeout_resp got err=%b rdata=%h stray=%b exp 1 0 0", err, rdata, stray);
    end
    run_access(1'b0, 1'b0, 32'h84, 32'h0, 1, 32'hA5A5A5A5, lat, strobes, rdata, err, stray);
    checks++;
    if (lat != 2 || err !== 1'b0 || rdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL after_timeout got ack@%0d err=%b rdata=%h exp 2 0 a5a5a5a5", lat, err, rdata);
    end
  endtask

  task automatic test_ready_at_limit();
    int unsigned lat, strobes;
    logic [31:0] rdata;
    logic err;
    bit stray;
    run_access(1'b1, 1'b0, 32'h140, 32'h0, 15, 32'h0BADC0DE, lat, strobes, rdata, err, stray);
    checks++;
    if (lat != 16 || strobes != 15) begin
      errors++;
      $display("FAIL limit_latency got ack@%0d strobes=%0d exp 16 15", lat, strobes);
    end
    checks++;
    if (err !== 1'b0 || rdata !== 32'h0BADC0DE || stray) begin
      errors++;
      $display("FAIL limit_resp got err=%b rdata=%h stray=%b exp 0 0badc0de 0", err, rdata, stray);
    end
  endtask

  task automatic test_reset_mid_access();
    int unsigned acks, lat, strobes;
    logic [31:0] rdata;
    logic err;
    bit stray;
    acks = 0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h200; bus.cpu_wdata = 32'h55AA55AA;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mem_write !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_write got mem_write=%b exp 1", bus.mem_write);
    end
    reset = 1'b0; bus.cpu_req = 1'b0;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_async got mem_write=%b busy=%b addr=%h exp 0 0 0",
               bus.mem_write, bus.busy, bus.mem_addr);
    end
    for (int unsigned c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.dma_ack) acks++;
      if (c == 2) reset = 1'b1;
    end
    checks++;
    if (acks != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_ack got acks=%0d busy=%b exp 0 0", acks, bus.busy);
    end
    run_access(1'b0, 1'b0, 32'h204, 32'h0, 2, 32'h600DF00D, lat, strobes, rdata, err, stray);
    checks++;
    if (lat != 3 || err !== 1'b0 || rdata !== 32'h600DF00D) begin
      errors++;
      $display("FAIL rst_fresh got ack@%0d err=%b rdata=%h exp 3 0 600df00d", lat, err, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_arbitration();
    test_loser_pending();
    test_timeout();
    test_ready_at_limit();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
